// File: rtl/issue_ctrl_if.sv
// Issue-stage bundle between the IF FIFO / decode heads and the dual-issue scheduler.
`default_nettype none

interface issue_ctrl_if;
  logic       fifo_valid0;
  logic       fifo_valid1;
  logic       s0_wb_en;
  logic [4:0] s0_wb_dest;
  logic [4:0] s0_rs;
  logic [4:0] s0_rt;
  logic       s0_is_branch;
  logic       s0_is_priv;
  logic       s1_simple;
  logic [4:0] s1_wb_dest;
  logic [4:0] s1_rs;
  logic [4:0] s1_rt;
  logic       ex_is_load;
  logic [4:0] ex_load_dest;
  logic       mem_busy;
  logic       exc_req;
  logic [1:0] pop_cnt;
  logic       slave_real;
  logic       en_id_ex;
  logic       en_ex_mem;
  logic       en_mem_wb;
  logic       flush;

  modport master (
    output fifo_valid0, fifo_valid1, s0_wb_en, s0_wb_dest, s0_rs, s0_rt,
           s0_is_branch, s0_is_priv, s1_simple, s1_wb_dest, s1_rs, s1_rt,
           ex_is_load, ex_load_dest, mem_busy, exc_req,
    input  pop_cnt, slave_real, en_id_ex, en_ex_mem, en_mem_wb, flush
  );

  modport slave (
    input  fifo_valid0, fifo_valid1, s0_wb_en, s0_wb_dest, s0_rs, s0_rt,
           s0_is_branch, s0_is_priv, s1_simple, s1_wb_dest, s1_rs, s1_rt,
           ex_is_load, ex_load_dest, mem_busy, exc_req,
    output pop_cnt, slave_real, en_id_ex, en_ex_mem, en_mem_wb, flush
  );
endinterface

`default_nettype wire

// File: rtl/issue_ctrl.sv
// Dual-issue scheduler: pop count, slave routing, shared stage enables/flush, perf counters.
// rst is active-low and asynchronous.
`default_nettype none

module issue_ctrl #(
  parameter bit DUAL_EN = 1'b1,
  parameter int CNT_W   = 32
) (
  input  wire logic             clk,
  input  wire logic             rst,
  issue_ctrl_if.slave           bus,
  output logic [1:0]            state,
  output logic [CNT_W-1:0]      dual_cnt,
  output logic [CNT_W-1:0]      stall_cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    FLUSH   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] dual_cnt_q, dual_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic       s0_load_use, s1_load_use, raw_hit, waw_hit, dual_ok;
  logic [1:0] pop_cnt;
  logic       en_id_ex, en_ex_mem, en_mem_wb, flush;

  // Branches never block pairing: the delay slot rides in the slave.
  logic unused_branch;
  assign unused_branch = bus.s0_is_branch;

  assign s0_load_use = bus.ex_is_load && (bus.ex_load_dest != 5'd0) &&
                       ((bus.ex_load_dest == bus.s0_rs) || (bus.ex_load_dest == bus.s0_rt));
  assign s1_load_use = bus.ex_is_load && (bus.ex_load_dest != 5'd0) &&
                       ((bus.ex_load_dest == bus.s1_rs) || (bus.ex_load_dest == bus.s1_rt));
  assign raw_hit     = bus.s0_wb_en && (bus.s0_wb_dest != 5'd0) &&
                       ((bus.s0_wb_dest == bus.s1_rs) || (bus.s0_wb_dest == bus.s1_rt));
  assign waw_hit     = bus.s0_wb_en && (bus.s0_wb_dest != 5'd0) &&
                       (bus.s0_wb_dest == bus.s1_wb_dest);
  assign dual_ok     = DUAL_EN && bus.fifo_valid1 && bus.s1_simple && !bus.s0_is_priv &&
                       !raw_hit && !waw_hit && !s1_load_use;

  always_comb begin
    state_d   = state_q;
    pop_cnt   = 2'd0;
    en_id_ex  = 1'b1;
    en_ex_mem = 1'b1;
    en_mem_wb = 1'b1;
    flush     = 1'b0;
    if (!rst) begin
      state_d = RUN;
    end else if (bus.exc_req) begin
      flush   = 1'b1;
      state_d = FLUSH;
    end else begin
      unique case (state_q)
        FLUSH: begin
          flush   = 1'b1;
          state_d = RUN;
        end
        MEMWAIT: begin
          en_id_ex  = 1'b0;
          en_ex_mem = 1'b0;
          en_mem_wb = 1'b0;
          if (!bus.mem_busy) state_d = RUN;
        end
        default: begin
          if (bus.mem_busy) begin
            en_id_ex  = 1'b0;
            en_ex_mem = 1'b0;
            en_mem_wb = 1'b0;
            state_d   = MEMWAIT;
          end else if (s0_load_use) begin
            en_id_ex = 1'b0;
          end else if (bus.fifo_valid0) begin
            pop_cnt = dual_ok ? 2'd2 : 2'd1;
          end
        end
      endcase
    end
  end

  always_comb begin
    dual_cnt_d  = dual_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if ((pop_cnt == 2'd2) && (dual_cnt_q != '1))
      dual_cnt_d = dual_cnt_q + CNT_W'(1);
    if (bus.fifo_valid0 && (pop_cnt == 2'd0) && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      dual_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      dual_cnt_q  <= dual_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.pop_cnt    = pop_cnt;
  assign bus.slave_real = (pop_cnt == 2'd2);
  assign bus.en_id_ex   = en_id_ex;
  assign bus.en_ex_mem  = en_ex_mem;
  assign bus.en_mem_wb  = en_mem_wb;
  assign bus.flush      = flush;
  assign state          = state_q;
  assign dual_cnt       = dual_cnt_q;
  assign stall_cnt      = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_issue_ctrl.sv
// Bench for issue_ctrl: directed scenarios plus randomized traffic against a rule-level model.
`default_nettype none

module tb_issue_ctrl;

  localparam longint MAX_M = 64'hFFFF_FFFF;
  localparam longint MAX_S = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  issue_ctrl_if bus ();
  issue_ctrl_if bus_s ();

  assign bus_s.fifo_valid0  = bus.fifo_valid0;
  assign bus_s.fifo_valid1  = bus.fifo_valid1;
  assign bus_s.s0_wb_en     = bus.s0_wb_en;
  assign bus_s.s0_wb_dest   = bus.s0_wb_dest;
  assign bus_s.s0_rs        = bus.s0_rs;
  assign bus_s.s0_rt        = bus.s0_rt;
  assign bus_s.s0_is_branch = bus.s0_is_branch;
  assign bus_s.s0_is_priv   = bus.s0_is_priv;
  assign bus_s.s1_simple    = bus.s1_simple;
  assign bus_s.s1_wb_dest   = bus.s1_wb_dest;
  assign bus_s.s1_rs        = bus.s1_rs;
  assign bus_s.s1_rt        = bus.s1_rt;
  assign bus_s.ex_is_load   = bus.ex_is_load;
  assign bus_s.ex_load_dest = bus.ex_load_dest;
  assign bus_s.mem_busy     = bus.mem_busy;
  assign bus_s.exc_req      = bus.exc_req;

  logic [1:0]  state, state_s;
  logic [31:0] dual_cnt, stall_cnt;
  logic [2:0]  dual_cnt_s, stall_cnt_s;

  issue_ctrl #(.DUAL_EN(1'b1), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .state(state), .dual_cnt(dual_cnt), .stall_cnt(stall_cnt)
  );

  issue_ctrl #(.DUAL_EN(1'b0), .CNT_W(3)) dut_s (
    .clk(clk), .rst(rst), .bus(bus_s),
    .state(state_s), .dual_cnt(dual_cnt_s), .stall_cnt(stall_cnt_s)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: state as 0=RUN 1=MEMWAIT 2=FLUSH, counters as unbounded ints clipped at max.
  int     m_state;
  longint m_dual, m_stall, m_dual_s, m_stall_s;
  int     x_pop, x_pop_s, x_nst;
  bit     x_fl;
  bit [2:0] x_en;

  task automatic predict();
    bit lu0, lu1, raw, waw, pair_ok;
    x_en = 3'b111; x_fl = 0; x_pop = 0; x_pop_s = 0; x_nst = m_state;
    if (rst !== 1'b1) begin
      x_nst = 0;
      return;
    end
    lu0 = bus.ex_is_load && bus.ex_load_dest != 0 &&
          (bus.ex_load_dest == bus.s0_rs || bus.ex_load_dest == bus.s0_rt);
    lu1 = bus.ex_is_load && bus.ex_load_dest != 0 &&
          (bus.ex_load_dest == bus.s1_rs || bus.ex_load_dest == bus.s1_rt);
    raw = bus.s0_wb_en && bus.s0_wb_dest != 0 &&
          (bus.s0_wb_dest == bus.s1_rs || bus.s0_wb_dest == bus.s1_rt);
    waw = bus.s0_wb_en && bus.s0_wb_dest != 0 && bus.s0_wb_dest == bus.s1_wb_dest;
    pair_ok = bus.fifo_valid1 && bus.s1_simple && !bus.s0_is_priv && !raw && !waw && !lu1;
    if (bus.exc_req) begin
      x_fl = 1; x_nst = 2;
    end else if (m_state == 2) begin
      x_fl = 1; x_nst = 0;
    end else if (m_state == 1) begin
      x_en = 3'b000; x_nst = bus.mem_busy ? 1 : 0;
    end else if (bus.mem_busy) begin
      x_en = 3'b000; x_nst = 1;
    end else if (lu0) begin
      x_en = 3'b011;
    end else if (bus.fifo_valid0) begin
      x_pop = pair_ok ? 2 : 1;
      x_pop_s = 1;
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_dual = 0; m_stall = 0; m_dual_s = 0; m_stall_s = 0;
  endtask

  task automatic tick();
    predict();
    @(posedge clk);
    if (rst !== 1'b1) begin
      model_reset();
    end else begin
      m_state = x_nst;
      if (x_pop == 2 && m_dual < MAX_M) m_dual++;
      if (bus.fifo_valid0 && x_pop == 0 && m_stall < MAX_M) m_stall++;
      if (bus.fifo_valid0 && x_pop_s == 0 && m_stall_s < MAX_S) m_stall_s++;
    end
    #1;
  endtask

  task automatic idle_inputs();
    bus.fifo_valid0 = 0; bus.fifo_valid1 = 0; bus.s0_wb_en = 0; bus.s0_wb_dest = 0;
    bus.s0_rs = 0; bus.s0_rt = 0; bus.s0_is_branch = 0; bus.s0_is_priv = 0;
    bus.s1_simple = 0; bus.s1_wb_dest = 0; bus.s1_rs = 0; bus.s1_rt = 0;
    bus.ex_is_load = 0; bus.ex_load_dest = 0; bus.mem_busy = 0; bus.exc_req = 0;
  endtask

  task automatic legal_pair();
    idle_inputs();
    bus.fifo_valid0 = 1; bus.fifo_valid1 = 1; bus.s1_simple = 1;
    bus.s0_wb_en = 1; bus.s0_wb_dest = 3; bus.s0_rs = 1; bus.s0_rt = 2;
    bus.s1_wb_dest = 6; bus.s1_rs = 4; bus.s1_rt = 5;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.fifo_valid0 = 1; bus.fifo_valid1 = 1; bus.s1_simple = 1;
    rst = 0;
    tick(); tick();
    #2;
    total++; if (bus.pop_cnt !== 2'd0) begin bad++; $display("FAIL reset_pop got=%0d want=0", bus.pop_cnt); end
    total++; if (bus.slave_real !== 1'b0 || bus.flush !== 1'b0) begin bad++; $display("FAIL reset_sreal_flush got=%b%b want=00", bus.slave_real, bus.flush); end
    total++; if ({bus.en_id_ex, bus.en_ex_mem, bus.en_mem_wb} !== 3'b111) begin bad++; $display("FAIL reset_en got=%b%b%b want=111", bus.en_id_ex, bus.en_ex_mem, bus.en_mem_wb); end
    total++; if (state !== 2'd0 || dual_cnt !== 32'd0 || stall_cnt !== 32'd0) begin bad++; $display("FAIL reset_regs got state=%0d dual=%0d stall=%0d want 0/0/0", state, dual_cnt, stall_cnt); end
    rst = 1;
  endtask

  task automatic test_dual_pair();
    longint d0;
    legal_pair();
    #2;
    total++; if (bus.pop_cnt !== 2'd2 || bus.slave_real !== 1'b1) begin bad++; $display("FAIL dual_pair got pop=%0d sreal=%b want 2/1", bus.pop_cnt, bus.slave_real); end
    d0 = longint'(dual_cnt);
    tick();
    total++; if (longint'(dual_cnt) !== d0 + 1) begin bad++; $display("FAIL dual_cnt_inc got=%0d want=%0d", dual_cnt, d0 + 1); end
  endtask

  task automatic test_raw();
    legal_pair();
    bus.s0_wb_dest = 8; bus.s1_rs = 8;
    #2;
    total++; if (bus.pop_cnt !== 2'd1 || bus.slave_real !== 1'b0) begin bad++; $display("FAIL raw_pair got pop=%0d sreal=%b want 1/0", bus.pop_cnt, bus.slave_real); end
    tick();
    bus.s0_wb_dest = 0; bus.s1_rs = 0;
    #2;
    total++; if (bus.pop_cnt !== 2'd2) begin bad++; $display("FAIL raw_r0 got pop=%0d want 2", bus.pop_cnt); end
    tick();
  endtask

  task automatic test_load_use();
    longint s0;
    legal_pair();
    bus.ex_is_load = 1; bus.ex_load_dest = 9; bus.s0_rt = 9;
    #2;
    total++; if ({bus.en_id_ex, bus.en_ex_mem, bus.en_mem_wb} !== 3'b011 || bus.pop_cnt !== 2'd0) begin bad++; $display("FAIL load_use got en=%b%b%b pop=%0d want 011/0", bus.en_id_ex, bus.en_ex_mem, bus.en_mem_wb, bus.pop_cnt); end
    s0 = longint'(stall_cnt);
    tick();
    total++; if (longint'(stall_cnt) !== s0 + 1) begin bad++; $display("FAIL load_use_stall got=%0d want=%0d", stall_cnt, s0 + 1); end
    bus.ex_is_load = 0;
    #2;
    total++; if (bus.pop_cnt === 2'd0 || $isunknown(bus.pop_cnt)) begin bad++; $display("FAIL load_use_clear got pop=%0d want >=1", bus.pop_cnt); end
    tick();
  endtask

  task automatic test_memwait();
    legal_pair();
    for (int i = 0; i < 4; i++) begin
      bus.mem_busy = (i < 3);
      #2;
      total++; if ({bus.en_id_ex, bus.en_ex_mem, bus.en_mem_wb} !== 3'b000 || bus.pop_cnt !== 2'd0) begin bad++; $display("FAIL memwait_en cyc=%0d got en=%b%b%b pop=%0d want 000/0", i, bus.en_id_ex, bus.en_ex_mem, bus.en_mem_wb, bus.pop_cnt); end
      tick();
      total++; if (state !== ((i < 3) ? 2'd1 : 2'd0)) begin bad++; $display("FAIL memwait_state cyc=%0d got=%0d want=%0d", i, state, (i < 3) ? 1 : 0); end
    end
    #2;
    total++; if (bus.pop_cnt !== 2'd2) begin bad++; $display("FAIL memwait_resume got pop=%0d want 2", bus.pop_cnt); end
    tick();
  endtask

  task automatic test_exc_memwait();
    legal_pair();
    bus.mem_busy = 1;
    tick();
    total++; if (state !== 2'd1) begin bad++; $display("FAIL exc_pre_state got=%0d want=1", state); end
    bus.exc_req = 1;
    #2;
    total++; if (bus.flush !== 1'b1 || bus.pop_cnt !== 2'd0 || bus.slave_real !== 1'b0) begin bad++; $display("FAIL exc_flush1 got flush=%b pop=%0d sreal=%b want 1/0/0", bus.flush, bus.pop_cnt, bus.slave_real); end
    tick();
    total++; if (state !== 2'd2) begin bad++; $display("FAIL exc_state_flush got=%0d want=2", state); end
    bus.exc_req = 0;
    #2;
    total++; if (bus.flush !== 1'b1 || bus.pop_cnt !== 2'd0) begin bad++; $display("FAIL exc_flush2 got flush=%b pop=%0d want 1/0", bus.flush, bus.pop_cnt); end
    tick();
    total++; if (state !== 2'd0) begin bad++; $display("FAIL exc_state_run got=%0d want=0", state); end
    bus.mem_busy = 0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 63) != 0);
      bus.fifo_valid0  = ($urandom_range(0, 7) != 0);
      bus.fifo_valid1  = ($urandom_range(0, 3) != 0);
      bus.s0_wb_en     = $urandom_range(0, 1);
      bus.s0_wb_dest   = 5'($urandom_range(0, 3));
      bus.s0_rs        = 5'($urandom_range(0, 7));
      bus.s0_rt        = 5'($urandom_range(0, 7));
      bus.s0_is_branch = $urandom_range(0, 1);
      bus.s0_is_priv   = ($urandom_range(0, 7) == 0);
      bus.s1_simple    = ($urandom_range(0, 3) != 0);
      bus.s1_wb_dest   = 5'($urandom_range(0, 3));
      bus.s1_rs        = 5'($urandom_range(0, 7));
      bus.s1_rt        = 5'($urandom_range(0, 7));
      bus.ex_is_load   = ($urandom_range(0, 3) == 0);
      bus.ex_load_dest = 5'($urandom_range(0, 7));
      bus.mem_busy     = ($urandom_range(0, 7) == 0);
      bus.exc_req      = ($urandom_range(0, 15) == 0);
      #2;
      predict();
      total++;
      if (bus.pop_cnt !== 2'(x_pop) || bus.slave_real !== (x_pop == 2) || bus.flush !== x_fl ||
          {bus.en_id_ex, bus.en_ex_mem, bus.en_mem_wb} !== x_en) begin
        bad++;
        $display("FAIL rand_out n=%0d got pop=%0d sr=%b fl=%b en=%b%b%b want pop=%0d fl=%b en=%b",
                 n, bus.pop_cnt, bus.slave_real, bus.flush, bus.en_id_ex, bus.en_ex_mem, bus.en_mem_wb, x_pop, x_fl, x_en);
      end
      total++;
      if (bus_s.pop_cnt !== 2'(x_pop_s) || bus_s.slave_real !== 1'b0) begin
        bad++; $display("FAIL rand_single n=%0d got pop=%0d sr=%b want pop=%0d sr=0", n, bus_s.pop_cnt, bus_s.slave_real, x_pop_s);
      end
      tick();
      total++;
      if (state !== 2'(m_state) || state_s !== 2'(m_state) || longint'(dual_cnt) !== m_dual ||
          longint'(stall_cnt) !== m_stall || longint'(stall_cnt_s) !== m_stall_s || dual_cnt_s !== 3'd0) begin
        bad++;
        $display("FAIL rand_regs n=%0d got st=%0d/%0d dual=%0d stall=%0d stall_s=%0d dual_s=%0d want st=%0d dual=%0d stall=%0d stall_s=%0d dual_s=0",
                 n, state, state_s, dual_cnt, stall_cnt, stall_cnt_s, dual_cnt_s, m_state, m_dual, m_stall, m_stall_s);
      end
    end
    rst = 1;
    idle_inputs();
    tick(); tick();
  endtask

  task automatic test_single_issue_saturate();
    rst = 0; #1; rst = 1;
    model_reset();
    legal_pair();
    for (int i = 0; i < 4; i++) begin
      #2;
      total++; if (bus_s.pop_cnt !== 2'd1 || bus_s.slave_real !== 1'b0 || bus.pop_cnt !== 2'd2) begin bad++; $display("FAIL single_issue cyc=%0d got pop_s=%0d sr_s=%b pop=%0d want 1/0/2", i, bus_s.pop_cnt, bus_s.slave_real, bus.pop_cnt); end
      tick();
    end
    bus.mem_busy = 1;
    for (int i = 0; i < 11; i++) tick();
    total++; if (stall_cnt_s !== 3'd7 || dual_cnt_s !== 3'd0) begin bad++; $display("FAIL sat_hold got stall_s=%0d dual_s=%0d want 7/0", stall_cnt_s, dual_cnt_s); end
    total++; if (longint'(stall_cnt) !== m_stall || m_stall != 11) begin bad++; $display("FAIL sat_wide got stall=%0d want=11", stall_cnt); end
    bus.mem_busy = 0;
    tick();
  endtask

  initial begin
    model_reset();
    idle_inputs();
    rst = 0;
    #3;
    test_reset();
    test_dual_pair();
    test_raw();
    test_load_use();
    test_memwait();
    test_exc_memwait();
    test_random();
    test_single_issue_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/issue_ctrl.md
# issue_ctrl

Dual-issue scheduler for the master/slave pipeline pair. Each cycle it inspects the two head entries of the IF instruction FIFO and decides how many to pop (0, 1 or 2). It routes the second entry to the slave pipeline only when that is legal. It also drives the shared stage enables and the flush that both pipelines consume, handling load-use bubbles, memory-wait freezes and exception flushes. Two saturating performance counters are kept.

## Interface
- DUAL_EN, 1, 0 forces single issue; the slave never receives a real instruction.
- CNT_W, 32, width of the performance counters.

- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- fifo_valid0  in  1  FIFO head entry valid
- fifo_valid1  in  1  FIFO second entry valid
- s0_wb_en  in  1  head instruction writes a GPR
- s0_wb_dest  in  5  head destination GPR
- s0_rs, s0_rt  in  5 each  head source GPRs
- s0_is_branch  in  1  head is a branch or jump
- s0_is_priv  in  1  head is syscall/break/eret/mtc0/mfc0
- s1_simple  in  1  second entry is slave-capable (ALU/shift/immediate only)
- s1_wb_dest  in  5  second entry destination
- s1_rs, s1_rt  in  5 each  second entry sources
- ex_is_load  in  1  master ID/EX holds a load
- ex_load_dest  in  5  that load's destination
- mem_busy  in  1  data-memory access not complete
- exc_req  in  1  exception/eret redirect from the exception control unit
- pop_cnt  out  2  entries popped this cycle
- slave_real  out  1  drives the slave is_real_instruction
- en_id_ex, en_ex_mem, en_mem_wb  out  1 each  stage enables
- flush  out  1  pipeline flush
- state  out  2  current FSM state (debug)
- dual_cnt  out  CNT_W  cycles with pop_cnt=2
- stall_cnt  out  CNT_W  cycles with pop_cnt=0 and fifo_valid0=1

## Operation
- States: RUN=0, MEMWAIT=1, FLUSH=2. Reset state is RUN.
- Priority each cycle: exc_req, then mem_busy, then load-use, then issue.
- exc_req=1 in any state:
  - flush=1, pop_cnt=0, slave_real=0 this cycle.
  - Next state is FLUSH.
- FLUSH lasts one cycle: flush=1, pop_cnt=0, then RUN (unless exc_req again, which stays in FLUSH).
- RUN with mem_busy=1:
  - all three enables 0, pop_cnt=0.
  - Next state is MEMWAIT.
- MEMWAIT: all enables 0, pop_cnt=0.
  - Sampled mem_busy=0 goes to RUN on the next edge (one resume cycle).
- Load-use hazard: RUN, ex_is_load=1, ex_load_dest≠0, and ex_load_dest equals s0_rs or s0_rt.
  - en_id_ex=0, en_ex_mem=1, en_mem_wb=1. This bubbles ID/EX.
  - pop_cnt=0.
- Issue in RUN with no hazard: all enables 1.
  - pop_cnt=0 if fifo_valid0=0.
  - Otherwise pop_cnt=2 when dual is legal, else 1.
- Dual legal requires all of:
  - DUAL_EN=1, fifo_valid1=1, s1_simple=1, s0_is_priv=0.
  - No RAW: not (s0_wb_en, s0_wb_dest≠0, and s0_wb_dest∈{s1_rs,s1_rt}).
  - No WAW: not (s0_wb_en and s0_wb_dest=s1_wb_dest≠0).
  - Load-use check on s1 sources: ex_is_load with ex_load_dest≠0 matching s1_rs or s1_rt blocks dual.
  - s0_is_branch=1 does not block dual; the delay slot pairs with its branch.
- If s0_is_branch=1 and dual is illegal, issue 1 normally.
- slave_real = (pop_cnt==2).
- Counters:
  - dual_cnt increments when pop_cnt=2.
  - stall_cnt increments when fifo_valid0=1 and pop_cnt=0.
  - Both saturate at all-ones and never wrap.

## Timing
- Reset values: state=RUN, dual_cnt=0, stall_cnt=0.
- During reset, outputs are pop_cnt=0, slave_real=0, flush=0, and all enables=1.
- pop_cnt, slave_real, the enables and flush are combinational from state and the current inputs.
- state and the counters update on the rising clk edge.
- rst deassertion mid-operation is clean: the first active edge evaluates in RUN.
- exc_req coincident with mem_busy: flush wins, next state is FLUSH, and mem_busy is ignored that cycle.
- mem_busy high during FLUSH is ignored. RUN re-evaluates it.

## Test plan
- Two independent ALU ops (s0 dest 3, s1 rs 4 rt 5, s1_simple=1) -> pop_cnt=2, slave_real=1, dual_cnt 0→1.
- RAW pair: s0_wb_dest=8, s1_rs=8 -> pop_cnt=1, slave_real=0. Same with s0_wb_dest=0 -> pop_cnt=2.
- Load-use: ex_is_load=1, ex_load_dest=9, s0_rt=9 -> en_id_ex=0, en_ex_mem=1, pop_cnt=0, stall_cnt+1. Next cycle with the hazard cleared -> pop_cnt≥1.
- mem_busy high for 3 cycles:
  - state reaches MEMWAIT, all enables 0 for 4 cycles.
  - state returns to RUN on the edge after mem_busy falls.
- exc_req pulse in MEMWAIT together with mem_busy=1 -> flush=1 for 2 consecutive cycles, state MEMWAIT→FLUSH→RUN.
- DUAL_EN=0 with a legal pair -> pop_cnt=1 every cycle. Counter preloaded near saturation with all-ones stall condition holds at 2^CNT_W−1.
